apb_master: RTL and testbench

Single-transfer APB initiator that turns a valid/ready command request into a compliant APB SETUP/ACCESS sequence and returns the read data or error status as a one-cycle response pulse. It sits between the AHB-side bridge logic and the APB slave memory, driving the slave's address, data and write-enable, and is the initiating end of the APB link.

---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_wait_timer.sv | 50 +++++
 rtl/apb_master.sv | 136 +++++++++++++
 tb/tb_apb_master.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared state encoding, default sizes and the wait-timer width
// helper used by apb_master and apb_wait_timer.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int DEF_DSIZE   = 32;
    localparam int DEF_ASIZE   = 32;
    localparam int DEF_TIMEOUT = 16;

    // Wait counter only ever holds 0..timeout-1, so clog2(timeout) bits
    // suffice; keep at least one bit for timeout values of 1 or 2.
    function automatic int tmr_width(input int timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: counts not-ready ACCESS cycles of the current transfer
// and flags the cycle in which the wait limit is reached. Only instantiated
// when APB_TIMEOUT_EN is defined.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int            W    = tmr_width(TIMEOUT);
    localparam logic [W-1:0]  LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear on the way into ACCESS, otherwise count waits and
    // saturate at the limit so the counter never wraps during an abort.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value, independent of block ordering.
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The current wait cycle is the TIMEOUT-th one when the count of
    // earlier waits equals TIMEOUT-1.
    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/apb_master.sv
// apb_master: single-transfer APB initiator. Accepts one command on a
// valid/ready handshake, runs SETUP then ACCESS, and returns a one-cycle
// response pulse carrying read data and slave error status.
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT consecutive not-ready cycles (reported as rsp_err = 1).
module apb_master
    import apb_pkg::*;
#(
    parameter int DSIZE   = DEF_DSIZE,
    parameter int ASIZE   = DEF_ASIZE,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             Pclk,
    input  logic             Presetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [ASIZE-1:0] cmd_addr,
    input  logic [DSIZE-1:0] cmd_wdata,
    output logic             rsp_valid,
    output logic [DSIZE-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             Psel,
    output logic             Penable,
    output logic             Pwrite,
    output logic [ASIZE-1:0] Paddr,
    output logic [DSIZE-1:0] Pwdata,
    input  logic [DSIZE-1:0] Prdata,
    input  logic             Pready,
    input  logic             Pslverr
);

    apb_state_e       state_q, state_d;
    logic             pwrite_q, pwrite_d;
    logic [ASIZE-1:0] paddr_q, paddr_d;
    logic [DSIZE-1:0] pwdata_q, pwdata_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic [DSIZE-1:0] rsp_rdata_q, rsp_rdata_d;
    logic             timeout_abort;

`ifdef APB_TIMEOUT_EN
    logic tmr_expired;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk_i     (Pclk),
        .rst_ni    (Presetn),
        .clear_i   (state_q == SETUP),
        .inc_i     ((state_q == ACCESS) && !Pready),
        .expired_o (tmr_expired)
    );

    assign timeout_abort = (state_q == ACCESS) && !Pready && tmr_expired;
`else
    // Without the wait timer ACCESS waits indefinitely for Pready.
    logic [31:0] timeout_unused;
    assign timeout_unused = TIMEOUT;
    assign timeout_abort  = 1'b0;
`endif

    // Next-state and datapath: latch the command on acceptance, step
    // SETUP -> ACCESS, and build the response when ACCESS finishes.
    always_comb begin
        state_d     = state_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // A ready slave wins over a simultaneous timeout.
                if (Pready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = Pslverr;
                    rsp_rdata_d = pwrite_q ? '0 : Prdata;
                end else if (timeout_abort) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, APB request and response registers with synchronous reset.
    always_ff @(posedge Pclk) begin
        if (!Presetn) begin
            state_q     <= IDLE;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign Psel      = (state_q == SETUP) || (state_q == ACCESS);
    assign Penable   = (state_q == ACCESS);
    assign Pwrite    = pwrite_q;
    assign Paddr     = paddr_q;
    assign Pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: scoreboard bench for apb_master. The driver issues
// commands and pushes the expected response (value and completion cycle)
// into a queue; a monitor pops and compares on every rsp_valid and checks
// the APB signalling; a slave model answers with planned wait states.
module tb_apb_master;

    localparam int DSIZE   = 32;
    localparam int ASIZE   = 32;
    localparam int TIMEOUT = 4;

`ifdef APB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic             Pclk      = 1'b0;
    logic             Presetn   = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_write = 1'b0;
    logic [ASIZE-1:0] cmd_addr  = '0;
    logic [DSIZE-1:0] cmd_wdata = '0;
    logic [DSIZE-1:0] Prdata    = '0;
    logic             Pready    = 1'b0;
    logic             Pslverr   = 1'b0;
    logic             cmd_ready, rsp_valid, rsp_err;
    logic [DSIZE-1:0] rsp_rdata, Pwdata;
    logic [ASIZE-1:0] Paddr;
    logic             Psel, Penable, Pwrite;

    always #5 Pclk = ~Pclk;

    apb_master #(
        .DSIZE   (DSIZE),
        .ASIZE   (ASIZE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .Pclk      (Pclk),
        .Presetn   (Presetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .Psel      (Psel),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Prdata    (Prdata),
        .Pready    (Pready),
        .Pslverr   (Pslverr)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;   // data the slave returns for a read
        logic        err;     // Pslverr the slave returns
        int          waits;   // not-ready ACCESS cycles before Pready
    } cmd_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rsp_t;

    cmd_t plan_q[$];
    cmd_t apb_q[$];
    rsp_t exp_q[$];

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;

    always @(posedge Pclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: what the requester should see for a command whose
    // handshake happens at rising edge hs. Edge numbers count rising edges;
    // SETUP follows edge hs, the first ACCESS cycle follows edge hs+1, and
    // each ACCESS cycle k (0-based) ends at edge hs+2+k.
    function automatic rsp_t model(input cmd_t c, input int hs);
        rsp_t r;
        if (TMO_EN && c.waits >= TIMEOUT) begin
            // The TIMEOUT-th consecutive not-ready cycle is the last one.
            r.rdata = '0;
            r.err   = 1'b1;
            r.cyc   = hs + 2 + (TIMEOUT - 1);
        end else begin
            r.rdata = c.wr ? 32'h0 : c.rdata;
            r.err   = c.err;
            r.cyc   = hs + 2 + c.waits;
        end
        return r;
    endfunction

    function automatic cmd_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic err, input int waits);
        cmd_t c;
        c.wr = wr; c.addr = addr; c.wdata = wdata; c.rdata = rdata; c.err = err; c.waits = waits;
        return c;
    endfunction

    function automatic cmd_t rand_cmd(input int max_waits);
        cmd_t c;
        c.wr    = ($urandom_range(0, 1) == 1);
        c.addr  = $urandom;
        c.wdata = $urandom;
        c.rdata = $urandom;
        c.err   = ($urandom_range(0, 7) == 0);
        c.waits = $urandom_range(0, max_waits);
        return c;
    endfunction

    // Called at a falling edge; returns at the falling edge after the
    // handshake edge, with hs set to that edge number.
    task automatic send(input cmd_t c, output int hs);
        int budget;
        budget    = 0;
        hs        = -1;
        cmd_valid = 1'b1;
        cmd_write = c.wr;
        cmd_addr  = c.addr;
        cmd_wdata = c.wdata;
        while (!cmd_ready && budget < 300) begin
            @(negedge Pclk);
            budget++;
        end
        if (!cmd_ready) begin
            check("cmd_ready_wait_expired", cmd_ready, 1'b1);
            cmd_valid = 1'b0;
            return;
        end
        hs = cyc + 1;
        plan_q.push_back(c);
        apb_q.push_back(c);
        exp_q.push_back(model(c, hs));
        @(negedge Pclk);
        cmd_valid = 1'b0;
        cmd_wdata = $urandom;   // junk while busy: must not be re-latched
        cmd_addr  = $urandom;
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < 2000) begin
            @(negedge Pclk);
            b++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    // Slave model: plans are consumed in order at each SETUP; outside the
    // answering cycle it drives junk that the master must ignore.
    cmd_t s_cur;
    int   s_cnt = 0;
    always @(negedge Pclk) begin
        if (!Presetn) begin
            s_cnt   = 0;
            Pready  = 1'b0;
            Pslverr = 1'b0;
        end else if (Psel && !Penable) begin
            if (plan_q.size() != 0) s_cur = plan_q.pop_front();
            s_cnt   = 0;
            Pready  = 1'($urandom_range(0, 1));
            Pslverr = 1'($urandom_range(0, 1));
            Prdata  = $urandom;
        end else if (Psel && Penable) begin
            if (s_cnt < s_cur.waits) begin
                s_cnt++;
                Pready  = 1'b0;
                Pslverr = 1'($urandom_range(0, 1));
                Prdata  = $urandom;
            end else begin
                Pready  = 1'b1;
                Pslverr = s_cur.err;
                Prdata  = s_cur.rdata;
            end
        end else begin
            Pready  = 1'($urandom_range(0, 1));
            Pslverr = 1'($urandom_range(0, 1));
            Prdata  = $urandom;
        end
    end

    // Monitor: response scoreboard plus APB sequencing checks.
    cmd_t m_cur;
    rsp_t m_exp;
    logic prev_psel = 1'b0;
    always @(negedge Pclk) begin
        if (mon_en && Presetn) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", exp_q.size(), 1);
                end else begin
                    m_exp = exp_q.pop_front();
                    check("rsp_rdata", rsp_rdata, m_exp.rdata);
                    check("rsp_err", rsp_err, m_exp.err);
                    check("rsp_cycle", cyc, m_exp.cyc);
                    check("cmd_ready_during_rsp", cmd_ready, 1'b1);
                end
            end
            if (Psel && !Penable) begin
                if (apb_q.size() == 0) begin
                    check("setup_unexpected", apb_q.size(), 1);
                end else begin
                    m_cur = apb_q.pop_front();
                    check("setup_req", {Pwrite, Paddr, Pwdata}, {m_cur.wr, m_cur.addr, m_cur.wdata});
                end
                check("cmd_ready_in_setup", cmd_ready, 1'b0);
            end
            if (Psel && Penable) begin
                check("access_req_stable", {Pwrite, Paddr, Pwdata}, {m_cur.wr, m_cur.addr, m_cur.wdata});
                check("access_after_sel", prev_psel, 1'b1);
                check("cmd_ready_in_access", cmd_ready, 1'b0);
            end
            if (!Psel) check("penable_without_psel", Penable, 1'b0);
            prev_psel = Psel;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, hs1, hs2, hs3;
        cmd_t c;

        // Reset state
        repeat (3) @(negedge Pclk);
        check("reset_apb", {Psel, Penable, Pwrite, Paddr, Pwdata}, '0);
        check("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, '0);
        Presetn = 1'b1;
        @(negedge Pclk);
        check("reset_cmd_ready", cmd_ready, 1'b1);
        mon_en = 1'b1;

        // Write, zero-wait slave
        send(mk(1'b1, 32'h4, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 0), hs);
        check("wr_setup_phase", {Psel, Penable, Pwrite}, 3'b101);
        @(negedge Pclk);
        check("wr_access_phase", {Psel, Penable}, 2'b11);
        drain();

        // Read with two wait states
        send(mk(1'b0, 32'h4, 32'h0, 32'hDEAD_BEEF, 1'b0, 2), hs);
        drain();

        // Slave error on read of 0xF
        send(mk(1'b0, 32'hF, 32'h0, 32'h5555_AAAA, 1'b1, 0), hs);
        drain();
        check("rsp_single_pulse", rsp_valid, 1'b0);

        // Three back-to-back commands with cmd_valid held high
        send(mk(1'b1, 32'h100, 32'h1111_1111, 32'h0, 1'b0, 0), hs1);
        send(mk(1'b0, 32'h104, 32'h2222_2222, 32'h3333_3333, 1'b0, 0), hs2);
        send(mk(1'b1, 32'h108, 32'h4444_4444, 32'h0, 1'b1, 0), hs3);
        check("b2b_period_1", hs2 - hs1, 3);
        check("b2b_period_2", hs3 - hs2, 3);
        drain();

        // Reset during ACCESS
        send(mk(1'b0, 32'h40, 32'h0, 32'hCAFE_F00D, 1'b0, 50), hs);
        @(negedge Pclk);
        check("rst_mid_in_access", {Psel, Penable}, 2'b11);
        Presetn = 1'b0;
        @(negedge Pclk);
        check("rst_mid_apb_drop", {Psel, Penable}, 2'b00);
        check("rst_mid_no_rsp", rsp_valid, 1'b0);
        exp_q.delete();
        apb_q.delete();
        plan_q.delete();
        Presetn = 1'b1;
        @(negedge Pclk);
        check("rst_mid_cmd_ready", cmd_ready, 1'b1);
        check("rst_mid_no_rsp_after", rsp_valid, 1'b0);
        prev_psel = 1'b0;

        // Slave stuck not-ready: abort with the timer, otherwise keep waiting
        send(mk(1'b0, 32'h80, 32'h0, 32'hBEEF_0001, 1'b0, 200), hs);
        repeat (20) @(negedge Pclk);
        check("stuck_access_state", {Psel, Penable}, TMO_EN ? 2'b00 : 2'b11);
        drain();

        // Randomized traffic with random gaps and wait states
        for (int i = 0; i < 60; i++) begin
            c = rand_cmd(TMO_EN ? TIMEOUT : 5);
            send(c, hs);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 3)) @(negedge Pclk);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
